// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router register block and its neighbours.
//   DATA_W        : width of every byte moving through the router
//   ADDR_W        : width of the destination address field in the header
//   ADDR_INVALID  : reserved address; headers carrying it are ignored
//   router_state_e: encoding of the router FSM whose state decodes
//                   (detect_addr, lfd_state, ...) drive router_reg
//   addr_is_valid : true when a header byte carries a usable address
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    function automatic logic addr_is_valid(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_W-1:0] != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// -----------------------------------------------------------------------------
// router_parity_acc
// Running XOR accumulator for the packet parity computed by the router.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, forces acc to zero
//   clr  : synchronous clear at the start of a packet (wins over en)
//   en   : fold din into the accumulator this cycle
//   din  : byte to fold in
//   acc  : current accumulated parity
// -----------------------------------------------------------------------------
module router_parity_acc
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_reg ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg
// Datapath registers of the packet router: header capture, output byte
// steering, stall hold register, parity capture and parity error flag.
//   clk           : rising-edge clock
//   rst           : asynchronous active-high reset
//   pkt_valid     : source byte valid, low on the parity byte
//   data_in       : source byte (header, payload or parity)
//   fifo_full     : full flag of the FIFO selected by the header address
//   detect_addr   : FSM decoding the header byte
//   lfd_state     : FSM loading the first (header) byte into the FIFO
//   ld_state      : FSM loading payload / parity bytes
//   laf_state     : FSM loading the byte that was stalled by a full FIFO
//   full_state    : FSM waiting on a full FIFO
//   rst_int_req   : FSM request to clear the end-of-packet flag
//   dout          : byte written to the selected FIFO
//   parity_done   : packet parity byte has been captured
//   low_pkt_valid : end of packet seen while loading
//   err           : computed parity differs from the received parity byte
// -----------------------------------------------------------------------------
module router_reg
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_addr,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_req,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err
);

    logic [DATA_W-1:0] header_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] pkt_parity_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              parity_done_reg;
    logic              parity_done_d_reg;
    logic              low_pkt_valid_reg;
    logic              err_reg;

    logic              header_load;
    logic              hold_load;
    logic              pkt_parity_load;
    logic              acc_en;
    logic [DATA_W-1:0] acc_din;
    logic [DATA_W-1:0] int_parity;
    logic              parity_done_rise;

    assign header_load = detect_addr && pkt_valid && addr_is_valid(data_in);
    assign hold_load   = ld_state && fifo_full;

    // The parity byte arrives either directly in ld_state with room in the
    // FIFO, or after a stall where pkt_valid already dropped; the
    // !parity_done term keeps a lingering laf_state from recapturing it.
    assign pkt_parity_load = (ld_state && !fifo_full && !pkt_valid) ||
                             (laf_state && low_pkt_valid_reg && !parity_done_reg);

    // Payload bytes are folded in when first presented in ld_state, whether
    // they go straight out or into the hold register, so the replay in
    // laf_state never touches the accumulator.
    assign acc_en  = lfd_state || (ld_state && pkt_valid && !full_state);
    assign acc_din = lfd_state ? header_reg : data_in;

    router_parity_acc u_parity_acc (
        .clk (clk),
        .rst (rst),
        .clr (detect_addr),
        .en  (acc_en),
        .din (acc_din),
        .acc (int_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            header_reg <= '0;
        end else if (header_load) begin
            header_reg <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (hold_load) begin
            hold_reg <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg <= '0;
        end else if (lfd_state) begin
            dout_reg <= header_reg;
        end else if (ld_state && !fifo_full) begin
            dout_reg <= data_in;
        end else if (laf_state) begin
            dout_reg <= hold_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_pkt_valid_reg <= 1'b0;
        end else if (rst_int_req) begin
            low_pkt_valid_reg <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_parity_reg <= '0;
        end else if (pkt_parity_load) begin
            pkt_parity_reg <= data_in;
        end
    end

    // A new header clears the flag even if a parity capture coincides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_done_reg <= 1'b0;
        end else if (detect_addr) begin
            parity_done_reg <= 1'b0;
        end else if (pkt_parity_load) begin
            parity_done_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_done_d_reg <= 1'b0;
        end else begin
            parity_done_d_reg <= parity_done_reg;
        end
    end

    // Compare once, on the cycle after the parity byte lands, when both the
    // received byte and the accumulator are settled.
    assign parity_done_rise = parity_done_reg && !parity_done_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (detect_addr) begin
            err_reg <= 1'b0;
        end else if (parity_done_rise && (int_parity != pkt_parity_reg)) begin
            err_reg <= 1'b1;
        end
    end

    assign dout          = dout_reg;
    assign parity_done   = parity_done_reg;
    assign low_pkt_valid = low_pkt_valid_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_router_reg.sv
// -----------------------------------------------------------------------------
// tb_router_reg
// Directed bench for router_reg: each task plays one packet scenario by
// driving the FSM state decodes by hand and compares outputs with values
// worked out from the packet bytes.
// -----------------------------------------------------------------------------
module tb_router_reg;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_addr;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_req;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int checks;
    int errors;

    router_reg dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_req   (rst_int_req),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set every stimulus input for the coming edge.
    task automatic drive(input logic det, input logic lfd, input logic ld,
                         input logic laf, input logic full, input logic rint,
                         input logic pv, input logic ff, input logic [7:0] d);
        detect_addr = det;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = full;
        rst_int_req = rint;
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = d;
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        step();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++;
        if ({parity_done, low_pkt_valid, err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {parity_done, low_pkt_valid, err});
        end
        rst = 1'b0;
        step();
        $display("reset: dout=%h pd=%b lpv=%b err=%b", dout, parity_done, low_pkt_valid, err);
    endtask

    // Header 05, payload A1 3C 0F, parity byte given by caller.
    task automatic test_packet(input logic [7:0] par, input logic exp_err);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        step();
        checks++;
        if (parity_done !== 1'b0) begin errors++; $display("FAIL pkt_pd_clear got=%b exp=0", parity_done); end
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA1);
        step();
        checks++;
        if (dout !== 8'h05) begin errors++; $display("FAIL pkt_dout_hdr got=%h exp=05", dout); end
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'hA1);
        step();
        checks++;
        if (dout !== 8'hA1) begin errors++; $display("FAIL pkt_dout_p0 got=%h exp=a1", dout); end
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h3C);
        step();
        checks++;
        if (dout !== 8'h3C) begin errors++; $display("FAIL pkt_dout_p1 got=%h exp=3c", dout); end
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h0F);
        step();
        checks++;
        if (dout !== 8'h0F) begin errors++; $display("FAIL pkt_dout_p2 got=%h exp=0f", dout); end
        drive(0, 0, 1, 0, 0, 0, 0, 0, par);
        step();
        checks++;
        if (dout !== par) begin errors++; $display("FAIL pkt_dout_par got=%h exp=%h", dout, par); end
        checks++;
        if ({parity_done, low_pkt_valid, err} !== 3'b110) begin
            errors++; $display("FAIL pkt_par_flags got=%b exp=110", {parity_done, low_pkt_valid, err});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL pkt_err got=%b exp=%b", err, exp_err); end
        step();
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL pkt_err_hold got=%b exp=%b", err, exp_err); end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step();
        checks++;
        if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL pkt_lpv_clr got=%b exp=0", low_pkt_valid); end
        $display("packet: parity=%h err=%b", par, err);
    endtask

    task automatic test_err_clear();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h09);
        step();
        checks++;
        if ({err, parity_done} !== 2'b00) begin
            errors++; $display("FAIL errclr_flags got=%b exp=00", {err, parity_done});
        end
        $display("err_clear: err=%b pd=%b", err, parity_done);
    endtask

    // FIFO fills while 3C is presented; 3C is replayed from hold in laf.
    task automatic test_stall();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        step();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA1);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'hA1);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 1, 8'h3C);
        step();
        checks++;
        if (dout !== 8'hA1) begin errors++; $display("FAIL stall_dout_hold got=%h exp=a1", dout); end
        drive(0, 0, 0, 0, 1, 0, 1, 1, 8'h3C);
        step();
        checks++;
        if (dout !== 8'hA1) begin errors++; $display("FAIL stall_dout_full got=%h exp=a1", dout); end
        drive(0, 0, 0, 1, 0, 0, 1, 0, 8'h3C);
        step();
        checks++;
        if (dout !== 8'h3C) begin errors++; $display("FAIL stall_dout_laf got=%h exp=3c", dout); end
        checks++;
        if (parity_done !== 1'b0) begin errors++; $display("FAIL stall_pd_laf got=%b exp=0", parity_done); end
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h0F);
        step();
        checks++;
        if (dout !== 8'h0F) begin errors++; $display("FAIL stall_dout_p2 got=%h exp=0f", dout); end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h97);
        step();
        checks++;
        if (parity_done !== 1'b1) begin errors++; $display("FAIL stall_pd got=%b exp=1", parity_done); end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL stall_err got=%b exp=0", err); end
        $display("stall: dout=%h err=%b", dout, err);
    endtask

    // pkt_valid drops while the FIFO is full; parity is taken in laf_state.
    task automatic test_low_pkt_valid();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
        step();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA1);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'hA1);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h3C);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h0F);
        step();
        drive(0, 0, 1, 0, 0, 0, 0, 1, 8'h97);
        step();
        checks++;
        if ({low_pkt_valid, parity_done} !== 2'b10) begin
            errors++; $display("FAIL lpv_set got=%b exp=10", {low_pkt_valid, parity_done});
        end
        checks++;
        if (dout !== 8'h0F) begin errors++; $display("FAIL lpv_dout_hold got=%h exp=0f", dout); end
        drive(0, 0, 0, 0, 1, 0, 0, 1, 8'h97);
        step();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 8'h97);
        step();
        checks++;
        if ({parity_done, dout} !== {1'b1, 8'h97}) begin
            errors++; $display("FAIL lpv_laf_par got=%b/%h exp=1/97", parity_done, dout);
        end
        // A second laf cycle must not recapture the parity byte.
        drive(0, 0, 0, 1, 0, 0, 0, 0, 8'h55);
        step();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL lpv_err got=%b exp=0", err); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        checks++;
        if ({parity_done, err} !== 2'b10) begin
            errors++; $display("FAIL lpv_once got=%b exp=10", {parity_done, err});
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step();
        checks++;
        if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL lpv_clr got=%b exp=0", low_pkt_valid); end
        $display("low_pkt_valid: pd=%b lpv=%b err=%b", parity_done, low_pkt_valid, err);
    endtask

    // Header with address 3 is dropped; the previous header (05) is reused.
    task automatic test_invalid_addr();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h03);
        step();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h77);
        step();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h77);
        step();
        checks++;
        if (dout !== 8'h05) begin errors++; $display("FAIL invaddr_hdr got=%h exp=05", dout); end
        $display("invalid_addr: dout=%h", dout);
    endtask

    // detect_addr together with a parity capture condition: clear wins.
    task automatic test_detect_priority();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 8'h42);
        step();
        checks++;
        if (parity_done !== 1'b0) begin errors++; $display("FAIL detprio_pd got=%b exp=0", parity_done); end
        drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        step();
        $display("detect_priority: pd=%b", parity_done);
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h06);
        step();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'hA1);
        step();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'hA1);
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({dout, parity_done, low_pkt_valid, err} !== 11'd0) begin
            errors++; $display("FAIL areset_now got=%h/%b%b%b exp=00/000", dout, parity_done, low_pkt_valid, err);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        rst = 1'b0;
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h5A);
        step();
        checks++;
        if (dout !== 8'h5A) begin errors++; $display("FAIL areset_ld got=%h exp=5a", dout); end
        drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h5A);
        step();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL areset_hdr got=%h exp=00", dout); end
        $display("async_reset: dout=%h", dout);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        test_reset();
        test_packet(8'h97, 1'b0);
        test_packet(8'h96, 1'b1);
        test_err_clear();
        test_stall();
        test_low_pkt_valid();
        test_invalid_addr();
        test_detect_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 pkt_valid  input  1  source byte valid; falls on the parity byte cycle.
REQ-005 data_in  input  8  source byte (header, payload or parity).
REQ-006 fifo_full  input  1  full flag of the FIFO selected by the header address.
REQ-007 detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req  input  1 each  state decodes from the router FSM.
REQ-008 dout  output  8  byte to the selected FIFO.
REQ-009 parity_done  output  1  parity byte captured.
REQ-010 low_pkt_valid  output  1  end-of-packet seen while loading.
REQ-011 err  output  1  parity mismatch for the current packet.

Function
REQ-012 Header: when detect_addr=1, pkt_valid=1 and data_in[1:0]!=2'b11, SHALL latch data_in into header register; address 2'b11 is invalid and SHALL NOT be latched.
REQ-013 dout priority, per clock: lfd_state -> dout<=header; else ld_state and fifo_full=0 -> dout<=data_in; else laf_state -> dout<=hold; otherwise dout holds.
REQ-014 Hold: when ld_state=1 and fifo_full=1, SHALL capture data_in into hold register; dout unchanged that cycle.
REQ-015 low_pkt_valid SHALL set on the edge where ld_state=1 and pkt_valid=0; clear when rst_int_req=1; otherwise hold.
REQ-016 Packet parity register SHALL capture data_in when (ld_state=1, fifo_full=0, pkt_valid=0) or (laf_state=1, low_pkt_valid=1, parity_done=0).
REQ-017 parity_done SHALL set on the same edge as REQ-016 capture; clear when detect_addr=1; otherwise hold.
REQ-018 Internal parity (8-bit XOR): clear on detect_addr; XOR header on lfd_state; XOR data_in when ld_state=1, pkt_valid=1, full_state=0; hold otherwise.
REQ-019 Byte captured into hold (REQ-014) SHALL be XORed into internal parity at that capture, exactly once, never again on laf_state.
REQ-020 err SHALL set one cycle after parity_done rises if internal parity != packet parity; clear on detect_addr; otherwise hold.
REQ-021 Simultaneous detect_addr and parity_done set condition: detect_addr clear wins.
REQ-022 Payload length 1..63 bytes; no internal length counter; packet end defined solely by pkt_valid.

Reset
REQ-023 rst=1 SHALL asynchronously force dout=8'h00, parity_done=0, low_pkt_valid=0, err=0, header, hold, internal and packet parity=8'h00.
REQ-024 Reset mid-packet SHALL abandon the packet; first post-reset byte processed only via detect_addr.

Structure
REQ-025 Shared package router_pkg SHALL hold DATA_W=8, ADDR_W=2, ADDR_INVALID=2'b11; FSM state encodings also reside there.
REQ-026 One sub-module, router_parity_acc (clear/enable/XOR accumulator), SHALL implement REQ-018/019.

Verification
REQ-027 Header 8'h05 (addr 1), lfd then payload 8'hA1,8'h3C,8'h0F, parity 8'h97 (=05^A1^3C^0F) -> dout sequence 05,A1,3C,0F,97; parity_done=1; err stays 0.
REQ-028 Same packet, parity byte 8'h96 -> err=1 one cycle after parity_done; cleared on next detect_addr.
REQ-029 fifo_full=1 while data_in=8'h3C in ld_state -> dout holds 8'hA1; on laf_state dout=8'h3C; final parity check still passes.
REQ-030 pkt_valid drops during full, parity captured in laf_state with low_pkt_valid=1 -> parity_done=1 exactly once; rst_int_req clears low_pkt_valid.
REQ-031 Header data_in=8'h03 with detect_addr -> header not latched; subsequent lfd_state outputs previous header.
REQ-032 rst asserted between clock edges mid-payload -> all outputs 0 immediately, before next edge.
